banner_sprite_reader: RTL

Read-side companion to the 100x54 banner sprite RAM (victory/failure screen). It turns the VGA pixel stream into sprite RAM read addresses and absorbs the RAM's 1-cycle registered read latency. It drives a slide-in animation in which the banner drops from above the screen to its rest position, then holds. Its output is a keyed pixel plus an "on" flag that feeds the colour mapper's priority mux.

---
 rtl/banner_pkg.sv | 29 ++
 rtl/banner_addr_gen.sv | 34 +++
 rtl/banner_sprite_reader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/banner_pkg.sv
// Shared definitions for the victory/failure banner: sprite geometry, slide
// animation constants and the reader FSM state type.
package banner_pkg;

    localparam int SPR_W       = 100;
    localparam int SPR_H       = 54;
    localparam int ADDR_W      = 19;
    localparam int DEST_X      = 270;
    localparam int DEST_Y      = 213;
    localparam int SLIDE_STEP  = 4;
    localparam int HOLD_FRAMES = 120;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int CNT_W       = $clog2(HOLD_FRAMES + 1);

    localparam logic [23:0] KEY_COLOR = 24'h000000;

    typedef enum logic [1:0] {
        IDLE,
        SLIDE,
        HOLD
    } state_t;

    typedef logic signed [10:0] coord_t;

    // The banner starts fully above the visible area.
    localparam coord_t START_Y = coord_t'(-SPR_H);

endpackage

// File: rtl/banner_addr_gen.sv
// Stage-1 combinational logic: pixel position relative to the banner origin,
// bounds check and linear sprite RAM address.
module banner_addr_gen
    import banner_pkg::*;
(
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              pix_valid,
    input  logic              busy,
    input  coord_t            cur_y,
    output logic              in_box,
    output logic [ADDR_W-1:0] addr
);

    coord_t rel_x;
    coord_t rel_y;
    logic   on_screen;

    always_comb begin
        rel_x     = coord_t'({1'b0, draw_x}) - coord_t'(DEST_X);
        rel_y     = coord_t'({1'b0, draw_y}) - cur_y;
        on_screen = (int'(draw_x) < SCREEN_W) && (int'(draw_y) < SCREEN_H);
        // Sign bit clear means the offset is non-negative; rows above the
        // screen never match because draw_y is never negative.
        in_box    = pix_valid && busy && on_screen
                 && !rel_x[10] && (rel_x < coord_t'(SPR_W))
                 && !rel_y[10] && (rel_y < coord_t'(SPR_H));
        addr      = '0;
        if (in_box) begin
            addr = ADDR_W'(rel_y[5:0]) * ADDR_W'(SPR_W) + ADDR_W'(rel_x[6:0]);
        end
    end

endmodule

// File: rtl/banner_sprite_reader.sv
// Banner sprite read side: slide-in animation FSM, RAM address generation and
// a two-stage pixel pipeline matched to the RAM's registered read.
module banner_sprite_reader
    import banner_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              show,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid,
    output logic [ADDR_W-1:0] read_address,
    input  logic [23:0]       data_Out_vict,
    output logic [23:0]       pixel_out,
    output logic              pixel_on,
    output logic              pixel_out_valid,
    output logic              busy,
    output logic              hold_done
);

    state_t             state_q, state_d;
    logic               show_q;
    coord_t             cur_y_q, cur_y_d;
    coord_t             next_y;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               hold_done_q, hold_done_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               in_box_q, in_box_d;
    logic               in_box_d1_q;
    logic               valid_q, valid_d1_q;

    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cur_y_d     = cur_y_q;
        cnt_d       = cnt_q;
        hold_done_d = 1'b0;
        next_y      = cur_y_q + coord_t'(SLIDE_STEP);

        // Dropping show wins over any frame_start in the same cycle.
        if (!show) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!show_q) begin
                        state_d = SLIDE;
                        cur_y_d = START_Y;
                    end
                end
                SLIDE: begin
                    if (frame_start) begin
                        if (next_y >= coord_t'(DEST_Y)) begin
                            cur_y_d = coord_t'(DEST_Y);
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cur_y_d = next_y;
                        end
                    end
                end
                HOLD: begin
                    if (frame_start && (cnt_q != CNT_W'(HOLD_FRAMES))) begin
                        cnt_d       = cnt_q + CNT_W'(1);
                        hold_done_d = (cnt_d == CNT_W'(HOLD_FRAMES));
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    banner_addr_gen u_addr_gen (
        .draw_x    (DrawX),
        .draw_y    (DrawY),
        .pix_valid (pix_valid),
        .busy      (busy_q),
        .cur_y     (cur_y_q),
        .in_box    (in_box_d),
        .addr      (addr_d)
    );

    // NOTE: state uses non-blocking assignments so all flops update together
    // from values sampled before the edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            show_q      <= 1'b0;
            cur_y_q     <= START_Y;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hold_done_q <= 1'b0;
            addr_q      <= '0;
            in_box_q    <= 1'b0;
            in_box_d1_q <= 1'b0;
            valid_q     <= 1'b0;
            valid_d1_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            show_q      <= show;
            cur_y_q     <= cur_y_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            hold_done_q <= hold_done_d;
            addr_q      <= addr_d;
            in_box_q    <= in_box_d;
            in_box_d1_q <= in_box_q;
            valid_q     <= pix_valid;
            valid_d1_q  <= valid_q;
        end
    end

    // Stage 2 works directly on the RAM's registered read data.
    always_comb begin
        pixel_on  = in_box_d1_q && (data_Out_vict != KEY_COLOR);
        pixel_out = pixel_on ? data_Out_vict : 24'h000000;
    end

    assign read_address    = addr_q;
    assign pixel_out_valid = valid_d1_q;
    assign busy            = busy_q;
    assign hold_done       = hold_done_q;

endmodule
